codec_arbiter: RTL and testbench
================================

CODEC_ARBITER -- requirements
Module: codec_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 80, meaning uncompressed word width.
REQ-002 SHALL have parameter CODE_W, default 8, meaning compressed code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-007 SHALL have port req_cmd  input  4  command, bits [2i+1:2i] for requester i: 01 compress, 10 decompress.
REQ-008 SHALL have port req_data  input  2*DATA_W  word to compress, slice i per requester.
REQ-009 SHALL have port req_code  input  2*CODE_W  code to decompress, slice i per requester.
REQ-010 SHALL have port rsp_valid  output  2  per-requester response valid.
REQ-011 SHALL have port rsp_ready  input  2  per-requester response accept.
REQ-012 SHALL have port rsp_status  output  2  shared response status: 01 compressed, 10 decompressed, 11 error.
REQ-013 SHALL have port rsp_data  output  DATA_W  shared decompressed word.
REQ-014 SHALL have port rsp_code  output  CODE_W  shared compressed code.
REQ-015 SHALL have ports eng_command (output, 2), eng_data_in (output, DATA_W), eng_compressed_in (output, CODE_W) driving the compression engine.
REQ-016 SHALL have ports eng_compressed_out (input, CODE_W), eng_decompressed_out (input, DATA_W), eng_response (input, 2) from the engine.
REQ-017 SHALL have ports busy (output, 1) and err_count (output, 16).

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP; one transaction outstanding at a time.
REQ-019 In IDLE with any req_valid set: SHALL grant one requester, pulse its req_ready for one cycle, latch cmd/data/code, and record grant in last_grant.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester != last_grant; with one valid, grant it.
REQ-021 Latched cmd 01 or 10: IDLE -> ISSUE; cmd 00 or 11: IDLE -> RESP with rsp_status=11, rsp_data=0, rsp_code=0, no engine access.
REQ-022 ISSUE: eng_command = latched cmd for exactly one cycle, eng_data_in/eng_compressed_in = latched payload; next state CAPTURE.
REQ-023 CAPTURE: eng_command=00; at the clock edge ending CAPTURE, register eng_response->rsp_status, eng_compressed_out->rsp_code, eng_decompressed_out->rsp_data; next state RESP.
REQ-024 RESP: rsp_valid[grant]=1, other bit 0; rsp_* held stable until rsp_ready[grant]=1, then -> IDLE.
REQ-025 Latency: accept edge in cycle 0 -> rsp_valid high in cycle 3 (engine path), cycle 1 (illegal cmd).
REQ-026 eng_command SHALL be 00 in every state except ISSUE.
REQ-027 req_ready SHALL be 0 outside IDLE; requests arriving while busy wait (req_valid held by requester).
REQ-028 busy SHALL be 1 in any state other than IDLE.
REQ-029 rsp_ready on the non-granted bit SHALL be ignored.
REQ-030 Engine status 11 (dictionary full / bad code) SHALL be passed through unchanged with whatever code/data the engine presented.
REQ-031 IDLE -> next grant may occur in the cycle immediately after RESP completes.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state IDLE, last_grant=1 (requester 0 wins first), all outputs 0 (eng_command=00, req_ready=00, rsp_valid=00, rsp_status=00, rsp_data=0, rsp_code=0, busy=0, err_count=0).
REQ-033 Reset asserted mid-transaction SHALL abandon it; no response is delivered after reset release.

Configuration
REQ-034 Macro CODEC_ARB_ERRCNT_EN defined: err_count SHALL increment by 1 on each RESP entry with rsp_status=11, saturating at 16'hFFFF.
REQ-035 Macro CODEC_ARB_ERRCNT_EN undefined: err_count SHALL be tied to 0; counter logic absent.

Verification
REQ-036 Req0 cmd 01 data 80'h1234, engine responds 01/code 8'h00 -> req_ready[0] cycle 0, eng_command=01 cycle 1 only, rsp_valid[0]=1 cycle 3 with status 01, code 00.
REQ-037 Both valid (cmd 01, data 80'hA and 80'hB) after reset -> requester 0 served first, requester 1 second; repeat with both valid -> 0 then 1 alternates.
REQ-038 Req1 cmd 11 -> rsp_valid[1] cycle 1, status 11, eng_command stays 00, err_count 0->1 with CODEC_ARB_ERRCNT_EN.
REQ-039 Req0 cmd 10 code 8'h05, rsp_ready[0] held 0 for 5 cycles -> rsp_* stable all 5 cycles, req_ready 0 for both, completes when rsp_ready[0]=1.
REQ-040 reset_n low during CAPTURE -> all outputs 0 immediately, no rsp_valid after release, next grant goes to requester 0.

Source files
------------

// File: rtl/codec_arbiter.sv
// Two-requester round-robin front end for a single compress/decompress engine.
// Optional error counter enabled by defining CODEC_ARB_ERRCNT_EN.
module codec_arbiter #(
    parameter int DATA_W = 80,
    parameter int CODE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [3:0]            req_cmd,
    input  logic [2*DATA_W-1:0]   req_data,
    input  logic [2*CODE_W-1:0]   req_code,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [CODE_W-1:0]     rsp_code,
    output logic [1:0]            eng_command,
    output logic [DATA_W-1:0]     eng_data_in,
    output logic [CODE_W-1:0]     eng_compressed_in,
    input  logic [CODE_W-1:0]     eng_compressed_out,
    input  logic [DATA_W-1:0]     eng_decompressed_out,
    input  logic [1:0]            eng_response,
    output logic                  busy,
    output logic [15:0]           err_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic [1:0]          eng_cmd_q;
    logic [DATA_W-1:0]   data_q;
    logic [CODE_W-1:0]   code_q;
    logic [1:0]          rsp_valid_q;
    logic [1:0]          rsp_status_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [CODE_W-1:0]   rsp_code_q;

    logic                accept_d;
    logic                gnt_d;
    logic [1:0]          cmd_d;
    logic [DATA_W-1:0]   data_d;
    logic [CODE_W-1:0]   code_d;
    logic                legal_d;

    // With both requesters valid, the one not served last wins.
    always_comb begin
        gnt_d    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        cmd_d    = gnt_d ? req_cmd[3:2] : req_cmd[1:0];
        data_d   = gnt_d ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
        code_d   = gnt_d ? req_code[2*CODE_W-1:CODE_W] : req_code[CODE_W-1:0];
        legal_d  = (cmd_d == 2'b01) || (cmd_d == 2'b10);
        accept_d = (state_q == IDLE) && (req_valid != 2'b00);
    end

    // The accept strobe is a same-cycle handshake so the grant edge is cycle 0.
    assign req_ready         = (accept_d && reset_n) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
    assign busy              = (state_q != IDLE);
    assign eng_command       = eng_cmd_q;
    assign eng_data_in       = data_q;
    assign eng_compressed_in = code_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_status        = rsp_status_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_code          = rsp_code_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            eng_cmd_q    <= 2'b00;
            data_q       <= '0;
            code_q       <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_status_q <= 2'b00;
            rsp_data_q   <= '0;
            rsp_code_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        last_grant_q <= gnt_d;
                        data_q       <= data_d;
                        code_q       <= code_d;
                        if (legal_d) begin
                            eng_cmd_q <= cmd_d;
                            state_q   <= ISSUE;
                        end else begin
                            rsp_status_q <= 2'b11;
                            rsp_data_q   <= '0;
                            rsp_code_q   <= '0;
                            rsp_valid_q  <= gnt_d ? 2'b10 : 2'b01;
                            state_q      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    eng_cmd_q <= 2'b00;
                    state_q   <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_status_q <= eng_response;
                    rsp_code_q   <= eng_compressed_out;
                    rsp_data_q   <= eng_decompressed_out;
                    rsp_valid_q  <= last_grant_q ? 2'b10 : 2'b01;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[last_grant_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CODEC_ARB_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic        err_inc_d;

    // Counts every response that enters RESP carrying error status.
    assign err_inc_d = (accept_d && !legal_d) ||
                       ((state_q == CAPTURE) && (eng_response == 2'b11));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 16'h0000;
        end else if (err_inc_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_codec_arbiter.sv
// Self-checking bench for codec_arbiter: directed table, corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_codec_arbiter;
    localparam int DW = 80;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready, rsp_status;
    logic [3:0]      req_cmd;
    logic [2*DW-1:0] req_data;
    logic [2*CW-1:0] req_code;
    logic [DW-1:0]   rsp_data, eng_data_in, eng_decompressed_out;
    logic [CW-1:0]   rsp_code, eng_compressed_in, eng_compressed_out;
    logic [1:0]      eng_command, eng_response;
    logic            busy;
    logic [15:0]     err_count;

    always #5 clk = ~clk;

    codec_arbiter #(.DATA_W(DW), .CODE_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_data(req_data), .req_code(req_code),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_data(rsp_data), .rsp_code(rsp_code),
        .eng_command(eng_command), .eng_data_in(eng_data_in),
        .eng_compressed_in(eng_compressed_in),
        .eng_compressed_out(eng_compressed_out),
        .eng_decompressed_out(eng_decompressed_out),
        .eng_response(eng_response),
        .busy(busy), .err_count(err_count)
    );

    typedef struct {
        logic [1:0]    vld;
        logic [3:0]    cmd;
        logic [DW-1:0] d0, d1;
        logic [CW-1:0] c0, c1;
        logic [1:0]    er;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        int            dly;
        logic          g;
        int            lat;
    } vec_t;

    vec_t tbl[8];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   exp_err = 0;
    logic last_g = 1'b1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total_cnt++;
        if (act !== req)
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        else
            pass_cnt++;
    endtask

    function automatic logic [15:0] err_exp();
`ifdef CODEC_ARB_ERRCNT_EN
        return (exp_err > 65535) ? 16'hFFFF : 16'(exp_err);
`else
        return 16'h0000;
`endif
    endfunction

    // Reference model: grant choice and expected response for one transaction.
    task automatic run_txn(input vec_t v, input string tag);
        logic [1:0]    gc, es;
        logic          legal;
        logic [DW-1:0] edat, gd;
        logic [CW-1:0] ecod, gcode;
        int            cyc;
        gc    = v.g ? v.cmd[3:2] : v.cmd[1:0];
        legal = (gc == 2'b01) || (gc == 2'b10);
        es    = legal ? v.er : 2'b11;
        edat  = legal ? v.ed : '0;
        ecod  = legal ? v.ec : '0;
        gd    = v.g ? v.d1 : v.d0;
        gcode = v.g ? v.c1 : v.c0;
        if (es == 2'b11) exp_err++;

        @(negedge clk);
        req_valid = v.vld;
        req_cmd = v.cmd;
        req_data = {v.d1, v.d0};
        req_code = {v.c1, v.c0};
        eng_response = v.er;
        eng_compressed_out = v.ec;
        eng_decompressed_out = v.ed;
        #1 chk({tag, ".req_ready"}, 128'(req_ready), 128'(v.g ? 2'b10 : 2'b01));
        @(posedge clk);
        #1;
        // Requests arriving while busy must wait; payload changes must not leak.
        req_valid = 2'b11;
        req_cmd = 4'b0101;
        req_data = (2*DW)'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        req_code = 16'($urandom());
        @(negedge clk);
        cyc = 1;
        while (rsp_valid == 2'b00 && cyc < 10) begin
            chk({tag, ".eng_command"}, 128'(eng_command), 128'((cyc == 1 && legal) ? gc : 2'b00));
            if (cyc == 1 && legal) begin
                chk({tag, ".eng_data_in"}, 128'(eng_data_in), 128'(gd));
                chk({tag, ".eng_code_in"}, 128'(eng_compressed_in), 128'(gcode));
            end
            chk({tag, ".busy"}, 128'(busy), 128'(1'b1));
            chk({tag, ".ready_busy"}, 128'(req_ready), 128'(2'b00));
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, 128'(cyc), 128'(v.lat));
        chk({tag, ".eng_cmd_idle"}, 128'(eng_command), 128'(2'b00));
        eng_response = 2'($urandom());
        eng_compressed_out = 8'($urandom());
        eng_decompressed_out = DW'({$urandom(), $urandom(), $urandom()});
        for (int d = 0; d <= v.dly; d++) begin
            if (d > 0) begin
                rsp_ready = v.g ? 2'b01 : 2'b10;
                @(negedge clk);
            end
            chk({tag, ".rsp_valid"}, 128'(rsp_valid), 128'(v.g ? 2'b10 : 2'b01));
            chk({tag, ".rsp_status"}, 128'(rsp_status), 128'(es));
            chk({tag, ".rsp_data"}, 128'(rsp_data), 128'(edat));
            chk({tag, ".rsp_code"}, 128'(rsp_code), 128'(ecod));
            chk({tag, ".ready_resp"}, 128'(req_ready), 128'(2'b00));
        end
        req_valid = 2'b00;
        rsp_ready = v.g ? 2'b10 : 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk({tag, ".rsp_done"}, 128'(rsp_valid), 128'(2'b00));
        chk({tag, ".busy_done"}, 128'(busy), 128'(1'b0));
        chk({tag, ".err_count"}, 128'(err_count), 128'(err_exp()));
        last_g = v.g;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".eng_command"}, 128'(eng_command), 128'(2'b00));
        chk({tag, ".req_ready"}, 128'(req_ready), 128'(2'b00));
        chk({tag, ".rsp_valid"}, 128'(rsp_valid), 128'(2'b00));
        chk({tag, ".rsp_status"}, 128'(rsp_status), 128'(2'b00));
        chk({tag, ".rsp_data"}, 128'(rsp_data), 128'(0));
        chk({tag, ".rsp_code"}, 128'(rsp_code), 128'(0));
        chk({tag, ".busy"}, 128'(busy), 128'(1'b0));
        chk({tag, ".err_count"}, 128'(err_count), 128'(0));
    endtask

    initial begin
        vec_t v;
        logic [1:0] gc;
        tbl[0] = '{2'b01, 4'b0001, 80'h1234, 80'h0, 8'h00, 8'h00, 2'b01, 8'h00, 80'h0, 0, 1'b0, 3};
        tbl[1] = '{2'b11, 4'b0101, 80'hA, 80'hB, 8'h11, 8'h22, 2'b01, 8'h3C, 80'h0, 1, 1'b1, 3};
        tbl[2] = '{2'b11, 4'b0101, 80'hA, 80'hB, 8'h11, 8'h22, 2'b01, 8'h4D, 80'h0, 0, 1'b0, 3};
        tbl[3] = '{2'b10, 4'b1101, 80'h5, 80'h6, 8'h01, 8'h02, 2'b01, 8'h99, 80'h99, 0, 1'b1, 1};
        tbl[4] = '{2'b01, 4'b0010, 80'h0, 80'h0, 8'h05, 8'h00, 2'b10, 8'h00, 80'hDEAD, 5, 1'b0, 3};
        tbl[5] = '{2'b01, 4'b0000, 80'h7, 80'h0, 8'h07, 8'h00, 2'b10, 8'h55, 80'h55, 0, 1'b0, 1};
        tbl[6] = '{2'b10, 4'b1000, 80'h0, 80'h1, 8'h00, 8'hF0, 2'b11, 8'hEE, 80'h77, 2, 1'b1, 3};
        tbl[7] = '{2'b11, 4'b0101, 80'hC, 80'hD, 8'h33, 8'h44, 2'b01, 8'h12, 80'h34, 0, 1'b0, 3};

        reset_n = 1'b0;
        req_valid = 2'b11;
        req_cmd = 4'b0101;
        req_data = '1;
        req_code = '1;
        rsp_ready = 2'b11;
        eng_response = 2'b01;
        eng_compressed_out = 8'hFF;
        eng_decompressed_out = '1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset during CAPTURE abandons the transaction.
        @(negedge clk);
        req_valid = 2'b01;
        req_cmd = 4'b0001;
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.busy_before", 128'(busy), 128'(1'b1));
        reset_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_err = 0;
        last_g = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst.no_rsp", 128'(rsp_valid), 128'(2'b00));
        end
        v = tbl[7];
        v.g = 1'b0;
        run_txn(v, "post_rst0");
        v.g = 1'b1;
        run_txn(v, "post_rst1");

        for (int i = 0; i < 40; i++) begin
            v.vld = 2'($urandom_range(1, 3));
            v.cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : {2'($urandom_range(1, 2)), 2'($urandom_range(1, 2))};
            v.d0 = DW'({$urandom(), $urandom(), $urandom()});
            v.d1 = DW'({$urandom(), $urandom(), $urandom()});
            v.c0 = 8'($urandom());
            v.c1 = 8'($urandom());
            v.er = 2'($urandom());
            v.ec = 8'($urandom());
            v.ed = DW'({$urandom(), $urandom(), $urandom()});
            v.dly = $urandom_range(0, 3);
            v.g = (v.vld == 2'b11) ? ~last_g : v.vld[1];
            gc = v.g ? v.cmd[3:2] : v.cmd[1:0];
            v.lat = (gc == 2'b01 || gc == 2'b10) ? 3 : 1;
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
